reg_tag_scoreboard: RTL
=======================

Name: reg_tag_scoreboard

Overview:
- Tracks destination-register tags of instructions in the EX, MEM and WB stages of the 5-stage ARM pipeline.
- Compares each ID-stage source register against those tags, using 5-bit equality.
- Produces registered forwarding selects for the EX-stage operand muxes, and a combinational load-use stall for the PC/IF-ID registers.
- Feeds the forwarding muxes; the datapath register-number comparators consume its tags.

Parameters:
- REG_W, 5, register-number width.
- ZERO_REG, 31, register number that is never written or forwarded (XZR).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rn  input  REG_W  ID-stage source A register number.
- id_rm  input  REG_W  ID-stage source B register number.
- id_rn_used  input  1  source A is actually read.
- id_rm_used  input  1  source B is actually read.
- id_rd  input  REG_W  ID-stage destination register.
- id_reg_write  input  1  ID instruction writes id_rd.
- id_mem_read  input  1  ID instruction is a load (LDUR).
- flush  input  1  squash the ID instruction (taken branch).
- fwd_a  output  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result, 11 WB bypass.
- fwd_b  output  2  EX operand B select, same encoding as fwd_a.
- stall  output  1  hold PC and IF/ID, inject bubble into EX.

Behaviour:
- Internal tag stages EX, MEM, WB. Each holds {valid, rd[REG_W-1:0], is_load}.
- Every rising edge:
  - WB<=MEM and MEM<=EX, unconditionally.
  - EX<=ID entry when stall=0 and flush=0. The entry is valid = id_reg_write & (id_rd != ZERO_REG); is_load = id_mem_read.
  - Otherwise EX<=bubble (valid=0).
- Match rule for source A: matchX_A = id_rn_used & X.valid & (X.rd == id_rn) & (id_rn != ZERO_REG). Source B is identical using id_rm.
- Forward select, priority EX > MEM > WB:
  - EX match -> 01.
  - else MEM match -> 10.
  - else WB match -> 11.
  - else 00.
  - Computed combinationally in ID, registered into fwd_a/fwd_b. Latency 1 cycle, aligned with the instruction entering EX.
- Load-use hazard: hazard = (EX.is_load & EX.valid) & (matchEX_A | matchEX_B).
- stall = hazard & ~flush. This is combinational and the only combinational output.
- When stall or flush is set, fwd_a/fwd_b are registered as 00 (bubble).
- Stall lasts exactly 1 cycle per load-use pair. On the next cycle the load is in MEM, so the re-presented ID instruction gets 10.
- Stall for a source that is not used (used=0) must not occur.
- Simultaneous flush and hazard: flush wins, stall=0, EX gets bubble.
- Both sources match different stages: each select is resolved independently.
- Both sources match the same stage: both selects are equal.
- id_rd==ZERO_REG with id_reg_write=1: the EX entry is invalid, and no later match occurs.
- Reset, including mid-operation: all tag valids cleared, fwd_a=fwd_b=00, stall=0 in the cycle after reset is sampled, and stall stays 0 while reset is held. Reset takes precedence over flush and stall.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: WB tag stage is present; WB matches produce select 11.
- Undefined:
  - WB stage is omitted and select 11 is never produced.
  - WB-stage hazards are resolved by write-before-read in the register file.
  - MEM and EX behaviour is unchanged.

Test Plan:
- Cycle 0: ADD X3 (id_rd=3, reg_write=1). Cycle 1: id_rn=3, used=1 -> at cycle 2, fwd_a=01, fwd_b=00, stall never asserted.
- Cycle 0: writer rd=5. Cycle 1: unrelated instruction. Cycle 2: id_rm=5 -> fwd_b=10 at cycle 3. With a further bubble, the reader at cycle 3 gets fwd_b=11, or 00 if SCOREBOARD_WB_BYPASS_EN is undefined.
- LDUR X7 (mem_read=1, rd=7), then reader id_rn=7 -> stall=1 for exactly one cycle, fwd_a=00 registered. The next cycle re-presents the reader -> fwd_a=10, stall=0.
- Writers to 31 and load to 31, followed by readers of 31 -> fwd always 00, stall always 0. Reader id_rn=9 with id_rn_used=0 after LDUR X9 -> stall=0.
- LDUR X4, then reader of X4 with flush=1 in the same cycle -> stall=0, fwd registered 00. Consecutive writers X2 then X2 -> reader gets 01 (EX priority over MEM).
- Reset asserted mid-stream with a valid EX load pending -> next cycle all fwd=00, stall=0. A reader of the old tag after reset release gets 00.

Source files
------------

// File: rtl/reg_tag_scoreboard.sv
// reg_tag_scoreboard: destination-tag scoreboard for EX/MEM/WB with registered forwarding selects and a combinational load-use stall.
// Build option: define SCOREBOARD_WB_BYPASS_EN to keep the WB tag stage and the 11 (WB bypass) select.
module reg_tag_scoreboard #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall
);

  localparam logic [REG_W-1:0] ZERO_TAG = REG_W'(ZERO_REG);
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } tag_t;

  tag_t ex_tag;
  tag_t mem_tag;
  tag_t id_tag;
  logic ex_load;

  logic match_ex_a, match_ex_b;
  logic match_mem_a, match_mem_b;
  logic match_wb_a, match_wb_b;
  logic hazard;
  logic accept;
  logic [1:0] sel_a, sel_b;

  function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] src, input logic used);
    return used & t.valid & (t.rd == src) & (src != ZERO_TAG);
  endfunction

  function automatic logic [1:0] pick_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    if (m_ex)       return SEL_EX;
    else if (m_mem) return SEL_MEM;
    else if (m_wb)  return SEL_WB;
    else            return SEL_RF;
  endfunction

  // Writes to XZR never create a live tag, so they can never be matched later.
  always_comb begin
    id_tag       = '0;
    id_tag.valid = id_reg_write & (id_rd != ZERO_TAG);
    id_tag.rd    = id_rd;
  end

  always_comb begin
    match_ex_a  = tag_match(ex_tag, id_rn, id_rn_used);
    match_ex_b  = tag_match(ex_tag, id_rm, id_rm_used);
    match_mem_a = tag_match(mem_tag, id_rn, id_rn_used);
    match_mem_b = tag_match(mem_tag, id_rm, id_rm_used);
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  tag_t wb_tag;

  always_comb begin
    match_wb_a = tag_match(wb_tag, id_rn, id_rn_used);
    match_wb_b = tag_match(wb_tag, id_rm, id_rm_used);
  end

  always_ff @(posedge clk) begin
    if (reset) wb_tag <= '0;
    else       wb_tag <= mem_tag;
  end
`else
  // Without the WB stage the register file's write-before-read covers that distance.
  always_comb begin
    match_wb_a = 1'b0;
    match_wb_b = 1'b0;
  end
`endif

  always_comb begin
    sel_a  = pick_sel(match_ex_a, match_mem_a, match_wb_a);
    sel_b  = pick_sel(match_ex_b, match_mem_b, match_wb_b);
    hazard = ex_load & ex_tag.valid & (match_ex_a | match_ex_b);
    // Reset and flush both dominate the stall so the front end is never held while squashing.
    stall  = hazard & ~flush & ~reset;
    accept = ~stall & ~flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_tag  <= '0;
      ex_load <= 1'b0;
      mem_tag <= '0;
      fwd_a   <= SEL_RF;
      fwd_b   <= SEL_RF;
    end else begin
      mem_tag <= ex_tag;
      if (accept) begin
        ex_tag  <= id_tag;
        ex_load <= id_mem_read;
        fwd_a   <= sel_a;
        fwd_b   <= sel_b;
      end else begin
        ex_tag  <= '0;
        ex_load <= 1'b0;
        fwd_a   <= SEL_RF;
        fwd_b   <= SEL_RF;
      end
    end
  end

endmodule
